// File: rtl/mul_div_pkg.sv
// Shared constants and state type for the serial multiply / BCD conversion chain.
package mul_div_pkg;
   localparam int BIN_W      = 8;
   localparam int BCD_DIGITS = 3;
   localparam int STEPS      = 8;
   localparam int WORK_W     = BIN_W + 4 * BCD_DIGITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit field that is 5 or more.
module bcd_digit_adj (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   // Inputs never exceed 9 here, so the corrected value stays within 4 bits.
   assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_8bit_serial.sv
// Iterative 8-bit binary to 3-digit BCD converter, one add-3/shift step per clock.
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one correction/shift step per clock, 8 steps total
// DONE  | result valid; held until start returns low
module bin2bcd_8bit_serial
   import mul_div_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic [3:0]       bcd_hund,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_ones,
   output logic             busy,
   output logic             done
);
   conv_state_t       state_q, state_d;
   logic [WORK_W-1:0] work_q, work_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [3:0]        hund_q, hund_d;
   logic [3:0]        tens_q, tens_d;
   logic [3:0]        ones_q, ones_d;
   logic [3:0]        adj_h, adj_t, adj_o;
   logic [WORK_W-1:0] shifted;

   bcd_digit_adj u_adj_h (.din(work_q[BIN_W+11:BIN_W+8]), .dout(adj_h));
   bcd_digit_adj u_adj_t (.din(work_q[BIN_W+7:BIN_W+4]),  .dout(adj_t));
   bcd_digit_adj u_adj_o (.din(work_q[BIN_W+3:BIN_W]),    .dout(adj_o));

   assign shifted = {adj_h, adj_t, adj_o, work_q[BIN_W-1:0]} << 1;

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      hund_d  = hund_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               work_d  = {{(4*BCD_DIGITS){1'b0}}, bin};
               cnt_d   = 3'd0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            work_d = shifted;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'(STEPS - 1)) begin
               hund_d  = shifted[BIN_W+11:BIN_W+8];
               tens_d  = shifted[BIN_W+7:BIN_W+4];
               ones_d  = shifted[BIN_W+3:BIN_W];
               state_d = DONE;
            end
         end
         DONE: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         hund_q  <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         hund_q  <= hund_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
      end
   end

   assign bcd_hund = hund_q;
   assign bcd_tens = tens_q;
   assign bcd_ones = ones_q;
   assign busy     = (state_q == SHIFT);
   assign done     = (state_q == DONE);
endmodule

// File: tb/tb_bin2bcd_8bit_serial.sv
// Directed and sweep bench for the serial binary-to-BCD converter.
module tb_bin2bcd_8bit_serial;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] bin = 8'd0;
   logic [3:0] bcd_hund, bcd_tens, bcd_ones;
   logic       busy, done;
   int         n_chk = 0;
   int         n_pass = 0;

   bin2bcd_8bit_serial dut (
      .clk(clk), .rst(rst), .start(start), .bin(bin),
      .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for done after the start-sampling edge; returns edges counted.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   task automatic check_digits(input string tag, input int h, input int t, input int o);
      check({tag, "_hund"}, int'(bcd_hund), h);
      check({tag, "_tens"}, int'(bcd_tens), t);
      check({tag, "_ones"}, int'(bcd_ones), o);
   endtask

   // Full conversion with start dropped afterwards; caller sits just after an edge.
   task automatic convert(input string tag, input int v, input int h, input int t, input int o);
      int cyc;
      bin   = 8'(v);
      start = 1'b1;
      tick();
      check({tag, "_busy"}, int'(busy), 1);
      start = 1'b0;
      wait_done(cyc);
      check({tag, "_lat"}, cyc, 8);
      check_digits(tag, h, t, o);
      tick();
      check({tag, "_idle"}, int'(done), 0);
   endtask

   initial begin
      int cyc;
      #12;
      check("rst_hund", int'(bcd_hund), 0);
      check("rst_tens", int'(bcd_tens), 0);
      check("rst_ones", int'(bcd_ones), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst = 1'b0;
      tick();

      // 255 with start held: conversion, then hold in DONE.
      bin   = 8'd255;
      start = 1'b1;
      tick();
      check("max_busy", int'(busy), 1);
      wait_done(cyc);
      check("max_lat", cyc, 8);
      check("max_notbusy", int'(busy), 0);
      check_digits("max", 2, 5, 5);
      repeat (3) tick();
      check("max_hold", int'(done), 1);
      start = 1'b0;
      tick();
      check("max_release", int'(done), 0);

      convert("v0", 0, 0, 0, 0);
      convert("v99", 99, 0, 9, 9);
      convert("v100", 100, 1, 0, 0);
      convert("v160", 160, 1, 6, 0);

      // Asynchronous reset mid-conversion.
      bin   = 8'd123;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("abort_busy_pre", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      check_digits("abort", 0, 0, 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      #3 rst = 1'b0;
      tick();
      convert("v42", 42, 0, 4, 2);

      // bin and start wiggle during SHIFT; previous result held.
      bin   = 8'd200;
      start = 1'b1;
      tick();
      repeat (2) tick();
      bin   = 8'd17;
      start = 1'b0;
      tick();
      start = 1'b1;
      check_digits("hold_mid", 0, 4, 2);
      tick();
      start = 1'b0;
      check("glitch_busy", int'(busy), 1);
      wait_done(cyc);
      check("glitch_lat", cyc, 4);
      check_digits("glitch", 2, 0, 0);
      tick();

      // Start held across two intended conversions.
      bin   = 8'd5;
      start = 1'b1;
      tick();
      wait_done(cyc);
      check("once_lat", cyc, 8);
      bin = 8'd77;
      repeat (12) tick();
      check("once_done", int'(done), 1);
      check("once_busy", int'(busy), 0);
      check_digits("once", 0, 0, 5);
      start = 1'b0;
      tick();
      convert("v77", 77, 0, 7, 7);

      for (int v = 0; v < 256; v++) begin
         bin   = 8'(v);
         start = 1'b1;
         tick();
         start = 1'b0;
         wait_done(cyc);
         check($sformatf("sw%0d_lat", v), cyc, 8);
         check_digits($sformatf("sw%0d", v), v / 100, (v / 10) % 10, v % 10);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
